// File: rtl/bcd_updown_counter.sv
// Registered multi-digit BCD up/down counter with clear, validated load and wrap/saturate.
// Over/underflow and bad-load conditions are reported as one-cycle registered pulses.
module bcd_updown_counter #(
    parameter int DIGITS   = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  inc,
    input  logic                  dec,
    output logic [4*DIGITS-1:0]   q,
    output logic                  ovf,
    output logic                  udf,
    output logic                  err,
    output logic                  zero,
    output logic                  max
);

    localparam int                W       = 4 * DIGITS;
    localparam logic [W-1:0]      MAX_VAL = {DIGITS{4'h9}};

    logic [W-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;
    logic         udf_q, udf_d;
    logic         err_q, err_d;

    logic [W-1:0] incValue;
    logic [W-1:0] decValue;
    logic         incCarry;
    logic         decBorrow;
    logic         loadValid;
    logic         atMax;
    logic         atZero;

    assign atMax  = (count_q == MAX_VAL);
    assign atZero = (count_q == '0);

    // Per-digit ripple: a digit only moves while every lower digit is rolling over.
    always_comb begin
        incValue = count_q;
        incCarry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (incCarry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    incValue[4*i +: 4] = 4'd0;
                end else begin
                    incValue[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    incCarry           = 1'b0;
                end
            end
        end
    end

    always_comb begin
        decValue  = count_q;
        decBorrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (decBorrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    decValue[4*i +: 4] = 4'd9;
                end else begin
                    decValue[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    decBorrow          = 1'b0;
                end
            end
        end
    end

    always_comb begin
        loadValid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                loadValid = 1'b0;
            end
        end
    end

    // Command priority: clear, load, cancelling inc+dec, inc, dec, hold.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        err_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            if (loadValid) begin
                count_d = load_val;
            end else begin
                err_d = 1'b1;
            end
        end else if (inc && !dec) begin
            if (atMax) begin
                ovf_d = 1'b1;
                if (!SATURATE) begin
                    count_d = '0;
                end
            end else begin
                count_d = incValue;
            end
        end else if (dec && !inc) begin
            if (atZero) begin
                udf_d = 1'b1;
                if (!SATURATE) begin
                    count_d = MAX_VAL;
                end
            end else begin
                count_d = decValue;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            err_q   <= err_d;
        end
    end

    assign q    = count_q;
    assign ovf  = ovf_q;
    assign udf  = udf_q;
    assign err  = err_q;
    assign zero = atZero;
    assign max  = atMax;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: a wrapping and a saturating instance share stimulus and
// are compared against an integer-arithmetic model of the decimal count.
module tb_bcd_updown_counter;

    localparam int DIGITS = 3;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 999;

    logic         clk;
    logic         reset_n;
    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic         inc;
    logic         dec;

    logic [W-1:0] q0, q1;
    logic         ovf0, udf0, err0, zero0, max0;
    logic         ovf1, udf1, err1, zero1, max1;

    int checks;
    int errors;

    int expVal [2];
    bit expOvf [2];
    bit expUdf [2];
    bit expErr [2];

    bcd_updown_counter #(.DIGITS(DIGITS), .SATURATE(1'b0)) dutWrap (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .q(q0), .ovf(ovf0), .udf(udf0), .err(err0),
        .zero(zero0), .max(max0)
    );

    bcd_updown_counter #(.DIGITS(DIGITS), .SATURATE(1'b1)) dutSat (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .q(q1), .ovf(ovf1), .udf(udf1), .err(err1),
        .zero(zero1), .max(max1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] toBcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit bcdValid(input logic [W-1:0] b);
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int fromBcd(input logic [W-1:0] b);
        int r;
        int scale;
        r     = 0;
        scale = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r     = r + int'(b[4*i +: 4]) * scale;
            scale = scale * 10;
        end
        return r;
    endfunction

    // Drives one command for one edge and advances the decimal model for both instances.
    task automatic applyStimulus(input bit c, input bit l, input logic [W-1:0] lv,
                                 input bit i, input bit d);
        clr = c; load = l; load_val = lv; inc = i; dec = d;
        @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            expOvf[s] = 1'b0;
            expUdf[s] = 1'b0;
            expErr[s] = 1'b0;
            if (c) begin
                expVal[s] = 0;
            end else if (l) begin
                if (bcdValid(lv)) expVal[s] = fromBcd(lv);
                else              expErr[s] = 1'b1;
            end else if (i && !d) begin
                if (expVal[s] == MAXV) begin
                    expOvf[s] = 1'b1;
                    expVal[s] = (s == 1) ? MAXV : 0;
                end else begin
                    expVal[s] = expVal[s] + 1;
                end
            end else if (d && !i) begin
                if (expVal[s] == 0) begin
                    expUdf[s] = 1'b1;
                    expVal[s] = (s == 1) ? 0 : MAXV;
                end else begin
                    expVal[s] = expVal[s] - 1;
                end
            end
        end
        #1;
        clr = 1'b0; load = 1'b0; load_val = '0; inc = 1'b0; dec = 1'b0;
    endtask

    task automatic modelReset();
        for (int s = 0; s < 2; s++) begin
            expVal[s] = 0;
            expOvf[s] = 1'b0;
            expUdf[s] = 1'b0;
            expErr[s] = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clr = 1'b0; load = 1'b0; load_val = '0; inc = 1'b0; dec = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q0 !== 12'h000 || q1 !== 12'h000) begin
            errors++;
            $display("FAIL reset_q got %h/%h want 000/000", q0, q1);
        end
        checks++;
        if ({ovf0, udf0, err0, ovf1, udf1, err1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b want 000000", {ovf0, udf0, err0, ovf1, udf1, err1});
        end
        checks++;
        if ({zero0, max0, zero1, max1} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_flags got %b want 1010", {zero0, max0, zero1, max1});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_count_up_wrap();
        for (int n = 1; n <= 1000; n++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (q0 !== toBcd(n % 1000)) begin
                errors++;
                $display("FAIL wrap_q step %0d got %h want %h", n, q0, toBcd(n % 1000));
            end
            checks++;
            if (ovf0 !== (n == 1000)) begin
                errors++;
                $display("FAIL wrap_ovf step %0d got %b want %b", n, ovf0, (n == 1000));
            end
            checks++;
            if (q1 !== toBcd(expVal[1]) || ovf1 !== expOvf[1]) begin
                errors++;
                $display("FAIL sat_count step %0d got %h/%b want %h/%b",
                         n, q1, ovf1, toBcd(expVal[1]), expOvf[1]);
            end
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (ovf0 !== 1'b0 || q0 !== 12'h000) begin
            errors++;
            $display("FAIL wrap_ovf_drop got %b/%h want 0/000", ovf0, q0);
        end
    endtask

    task automatic test_load_carry();
        applyStimulus(1'b0, 1'b1, 12'h099, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (q0 !== 12'h100 || q1 !== 12'h100) begin
            errors++;
            $display("FAIL carry_inc got %h/%h want 100", q0, q1);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (q0 !== 12'h098 || q1 !== 12'h098) begin
            errors++;
            $display("FAIL borrow_dec got %h/%h want 098", q0, q1);
        end
        checks++;
        if ({ovf0, udf0, ovf1, udf1} !== 4'b0) begin
            errors++;
            $display("FAIL borrow_pulses got %b want 0000", {ovf0, udf0, ovf1, udf1});
        end
    endtask

    task automatic test_saturate();
        applyStimulus(1'b0, 1'b1, 12'h999, 1'b0, 1'b0);
        checks++;
        if (max0 !== 1'b1 || max1 !== 1'b1) begin
            errors++;
            $display("FAIL max_flag got %b/%b want 1/1", max0, max1);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (q1 !== 12'h999 || ovf1 !== 1'b1 || q0 !== 12'h000 || ovf0 !== 1'b1) begin
            errors++;
            $display("FAIL inc_at_max got sat %h/%b wrap %h/%b want 999/1 000/1", q1, ovf1, q0, ovf0);
        end
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (q1 !== 12'h000 || udf1 !== 1'b1 || q0 !== 12'h999 || udf0 !== 1'b1) begin
            errors++;
            $display("FAIL dec_at_zero got sat %h/%b wrap %h/%b want 000/1 999/1", q1, udf1, q0, udf0);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if ({ovf0, udf0, ovf1, udf1} !== 4'b0) begin
            errors++;
            $display("FAIL pulse_drop got %b want 0000", {ovf0, udf0, ovf1, udf1});
        end
    endtask

    task automatic test_load_err();
        applyStimulus(1'b0, 1'b1, 12'h321, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 12'h1A5, 1'b0, 1'b0);
        checks++;
        if (err0 !== 1'b1 || err1 !== 1'b1 || q0 !== 12'h321 || q1 !== 12'h321) begin
            errors++;
            $display("FAIL bad_load got err %b/%b q %h/%h want 1/1 321", err0, err1, q0, q1);
        end
        applyStimulus(1'b0, 1'b1, 12'h500, 1'b1, 1'b0);
        checks++;
        if (q0 !== 12'h500 || q1 !== 12'h500 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL load_wins got %h/%h err %b want 500 err 0", q0, q1, err0);
        end
    endtask

    task automatic test_cancel();
        applyStimulus(1'b0, 1'b1, 12'h042, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (q0 !== 12'h042 || q1 !== 12'h042 || {ovf0, udf0} !== 2'b00) begin
            errors++;
            $display("FAIL inc_dec_cancel got %h/%h want 042", q0, q1);
        end
        applyStimulus(1'b1, 1'b1, 12'h555, 1'b0, 1'b0);
        checks++;
        if (q0 !== 12'h000 || q1 !== 12'h000 || zero0 !== 1'b1) begin
            errors++;
            $display("FAIL clr_wins got %h/%h zero %b want 000 zero 1", q0, q1, zero0);
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(1'b0, 1'b1, 12'h777, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 12'hF77, 1'b0, 1'b0);
        checks++;
        if (err0 !== 1'b1 || q0 !== 12'h777) begin
            errors++;
            $display("FAIL pre_reset got err %b q %h want 1 777", err0, q0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (q0 !== 12'h000 || q1 !== 12'h000) begin
            errors++;
            $display("FAIL async_reset_q got %h/%h want 000", q0, q1);
        end
        checks++;
        if ({ovf0, udf0, err0, ovf1, udf1, err1} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset_pulses got %b want 000000", {ovf0, udf0, err0, ovf1, udf1, err1});
        end
        modelReset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic [W-1:0] lv;
        int           sel;
        bit           c, l, i, d;
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 99);
            c = (sel < 3);
            l = (sel >= 3 && sel < 12);
            i = (sel >= 12 && sel < 60) || (sel >= 95);
            d = (sel >= 55);
            case ($urandom_range(0, 5))
                0:       lv = W'($urandom_range(0, 4095));
                1:       lv = toBcd(MAXV - $urandom_range(0, 2));
                2:       lv = toBcd($urandom_range(0, 2));
                default: lv = toBcd($urandom_range(0, MAXV));
            endcase
            applyStimulus(c, l, lv, i, d);
            checks++;
            if (q0 !== toBcd(expVal[0]) || q1 !== toBcd(expVal[1])) begin
                errors++;
                $display("FAIL rand_q step %0d got %h/%h want %h/%h",
                         n, q0, q1, toBcd(expVal[0]), toBcd(expVal[1]));
            end
            checks++;
            if ({ovf0, udf0, err0, ovf1, udf1, err1} !==
                {expOvf[0], expUdf[0], expErr[0], expOvf[1], expUdf[1], expErr[1]}) begin
                errors++;
                $display("FAIL rand_pulses step %0d got %b want %b", n,
                         {ovf0, udf0, err0, ovf1, udf1, err1},
                         {expOvf[0], expUdf[0], expErr[0], expOvf[1], expUdf[1], expErr[1]});
            end
            checks++;
            if ({zero0, max0, zero1, max1} !==
                {expVal[0] == 0, expVal[0] == MAXV, expVal[1] == 0, expVal[1] == MAXV}) begin
                errors++;
                $display("FAIL rand_flags step %0d got %b for values %0d/%0d", n,
                         {zero0, max0, zero1, max1}, expVal[0], expVal[1]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_count_up_wrap();
        test_load_carry();
        test_saturate();
        test_load_err();
        test_cancel();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
